uart_mmio: RTL

Memory-mapped UART peripheral on the data-memory bus, alongside the RAM/tube data memory.
- The data memory's read mux ORs in `Read_data` from this block for UART addresses.
- CPU writes TXD to send a byte and reads RXD/CON to receive and poll.
- Format: 8N1 serial, LSB first, fixed baud set by parameter.
- Optional interrupt request to the CPU.

---
 rtl/uart_mmio_pkg.sv | 28 ++
 rtl/uart_mmio_if.sv | 13 +
 rtl/uart_rx_core.sv | 112 +++++++++++
 rtl/uart_mmio.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared constants and FSM state type for the memory-mapped UART.
// Register map, CON bit positions and the common IDLE/START/DATA/STOP encoding.
package uart_mmio_pkg;

  localparam logic [31:0] UART_ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] UART_ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] UART_ADDR_CON = 32'h4000_0020;

  localparam int TX_IRQ_EN = 0;
  localparam int RX_IRQ_EN = 1;
  localparam int TX_DONE   = 2;
  localparam int RX_DONE   = 3;
  localparam int TX_BUSY   = 4;
  localparam int RX_OVR    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic logic irq_from_con(input logic [1:0] en, input logic tx_done,
                                        input logic rx_done);
    return (en[0] & tx_done) | (en[1] & rx_done);
  endfunction

endpackage

// File: rtl/uart_mmio_if.sv
// Data-memory bus bundle seen by the UART: read/write strobes, address, store and load data.
interface uart_mmio_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;

  modport master (output MemRead, output MemWrite, output Address, output Write_data,
                  input Read_data);
  modport slave  (input MemRead, input MemWrite, input Address, input Write_data,
                  output Read_data);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchronizer, start-bit glitch filter, centre sampling, stop check.
// rx_valid_o pulses for one cycle at a good stop sample; rx_byte_o holds the byte then.
module uart_rx_core
  import uart_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic        sync1_q, sync2_q, prev_q;
  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_s;

  // Synchronizer and edge-history flops idle high so reset never looks like a start edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Receive FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Receive FSM next state: half-bit start check, then one sample per bit period
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = START;
          cnt_d   = '0;
        end else begin
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = sync2_q ? IDLE : DATA;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          valid_s = sync2_q;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_byte_o  = shift_q;
  assign rx_valid_o = valid_s;

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON registers, transmit FSM, level irq, combinational read mux.
// Optional macro UART_RX_OVERRUN_EN adds the CON[5] receive-overrun flag. CLKS_PER_BIT must be >= 4.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] ADDR_TXD     = UART_ADDR_TXD,
  parameter logic [31:0] ADDR_RXD     = UART_ADDR_RXD,
  parameter logic [31:0] ADDR_CON     = UART_ADDR_CON
) (
  input  logic        clk,
  input  logic        reset,
  uart_mmio_if.slave  bus,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    txd_q, txd_d;
  logic          tx_q, tx_d;
  logic          tx_done_evt_s;
  logic [7:0]    rxd_q, rxd_d;
  logic [1:0]    irq_en_q, irq_en_d;
  logic          tx_done_q, tx_done_d;
  logic          rx_done_q, rx_done_d;
  logic          irq_q, irq_d;
  logic          con_ovr_s;
  logic [5:0]    con_rd_s;
  logic [7:0]    rx_byte_s;
  logic          rx_valid_s;
  logic          wdata_unused_s;

  wire sel_txd_s  = (bus.Address == ADDR_TXD);
  wire sel_con_s  = (bus.Address == ADDR_CON);
  wire wr_txd_s   = bus.MemWrite & sel_txd_s;
  wire wr_con_s   = bus.MemWrite & sel_con_s;
  wire rd_con_s   = bus.MemRead & sel_con_s;
  wire tx_busy_s  = (tx_state_q != IDLE);

  // Only the low store byte lands in any register
  assign wdata_unused_s = ^bus.Write_data[31:8];

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx_i       (uart_rx),
    .rx_byte_o  (rx_byte_s),
    .rx_valid_o (rx_valid_s)
  );

  // Transmit FSM and line register; async reset returns the line high immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      txd_q      <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      txd_q      <= txd_d;
      tx_q       <= tx_d;
    end
  end

  // Transmit next state: line value is registered one step ahead of each bit period
  always_comb begin
    tx_state_d    = tx_state_q;
    tx_cnt_d      = tx_cnt_q;
    tx_bit_d      = tx_bit_q;
    txd_d         = txd_q;
    tx_d          = tx_q;
    tx_done_evt_s = 1'b0;
    case (tx_state_q)
      IDLE: begin
        if (wr_txd_s) begin
          txd_d      = bus.Write_data[7:0];
          tx_state_d = START;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
        end else begin
          tx_d       = 1'b1;
        end
      end
      START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_state_d = DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_d       = txd_q[0];
        end else begin
          tx_cnt_d   = tx_cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_d       = txd_q[tx_bit_q + 3'd1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_state_d    = IDLE;
          tx_cnt_d      = '0;
          tx_done_evt_s = 1'b1;
        end else begin
          tx_cnt_d      = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_state_d = IDLE;
        tx_cnt_d   = '0;
        tx_d       = 1'b1;
      end
    endcase
  end

  // CON/RXD next state: a set event on the same edge as a clearing read wins
  always_comb begin
    irq_en_d  = wr_con_s ? bus.Write_data[1:0] : irq_en_q;
    rxd_d     = rx_valid_s ? rx_byte_s : rxd_q;
    tx_done_d = tx_done_evt_s ? 1'b1 : (rd_con_s ? 1'b0 : tx_done_q);
    rx_done_d = rx_valid_s ? 1'b1 : (rd_con_s ? 1'b0 : rx_done_q);
    irq_d     = irq_from_con(irq_en_d, tx_done_d, rx_done_d);
  end

  // Register file and irq, which tracks CON without added delay
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_q  <= 2'b00;
      rxd_q     <= 8'h00;
      tx_done_q <= 1'b0;
      rx_done_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      irq_en_q  <= irq_en_d;
      rxd_q     <= rxd_d;
      tx_done_q <= tx_done_d;
      rx_done_q <= rx_done_d;
      irq_q     <= irq_d;
    end
  end

`ifdef UART_RX_OVERRUN_EN
  logic ovr_q, ovr_d;

  // Overrun: a good byte arrives while the previous one is still unacknowledged
  always_comb begin
    ovr_d = (rx_valid_s && rx_done_q) ? 1'b1 : (rd_con_s ? 1'b0 : ovr_q);
  end

  // Overrun flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign con_ovr_s = ovr_q;
`else
  assign con_ovr_s = 1'b0;
`endif

  // CON view assembled from the individual flag flops
  always_comb begin
    con_rd_s            = 6'b000000;
    con_rd_s[TX_IRQ_EN] = irq_en_q[0];
    con_rd_s[RX_IRQ_EN] = irq_en_q[1];
    con_rd_s[TX_DONE]   = tx_done_q;
    con_rd_s[RX_DONE]   = rx_done_q;
    con_rd_s[TX_BUSY]   = tx_busy_s;
    con_rd_s[RX_OVR]    = con_ovr_s;
  end

  // Zero-latency read mux; drives zero when not addressed so it can be ORed with memory
  always_comb begin
    bus.Read_data = 32'h0000_0000;
    if (bus.MemRead) begin
      case (bus.Address)
        ADDR_TXD: bus.Read_data = {24'h00_0000, txd_q};
        ADDR_RXD: bus.Read_data = {24'h00_0000, rxd_q};
        ADDR_CON: bus.Read_data = {26'h000_0000, con_rd_s};
        default:  bus.Read_data = 32'h0000_0000;
      endcase
    end else begin
      bus.Read_data = 32'h0000_0000;
    end
  end

  assign uart_tx = tx_q;
  assign irq     = irq_q;

endmodule
